// File: rtl/prop_sched.sv
// prop_sched: dirty-bit scheduled chain of assignment stages fed by a_q.
// Macro PROP_SCHED_CHANGE_DETECT_EN: only mark dependents when a value changes.
module prop_sched #(
    parameter int                 WIDTH = 4,
    parameter int                 DEPTH = 8,
    parameter logic [2*DEPTH-1:0] OP    = 16'hFA50,
    parameter logic [DEPTH-1:0]   SRC   = 8'hAA
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic                       done,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic [WIDTH-1:0]           rd_data,
    output logic [WIDTH-1:0]           a_out,
    output logic [7:0]                 eval_cnt
);

    localparam int IDXW = $clog2(DEPTH);

    // Stages that read a_q directly; stage 0 always does.
    localparam logic [DEPTH-1:0] A_MASK = ~SRC | DEPTH'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PROP = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [DEPTH-1:0] dirty_q;
    logic [DEPTH-1:0] dirty_d;
    logic [DEPTH-1:0] accept_mark;
    logic [7:0]       eval_cnt_q;
    logic             done_q;
    logic             in_ready_q;

    logic [IDXW-1:0]  sel_idx;
    logic [1:0]       op_sel;
    logic [WIDTH-1:0] src_val;
    logic [WIDTH-1:0] res_val;
    logic             mark_next;
    logic [WIDTH-1:0] rd_val;

`ifdef PROP_SCHED_CHANGE_DETECT_EN
    assign accept_mark = (in_data != a_q) ? A_MASK : '0;
`else
    assign accept_mark = A_MASK;
`endif

    // Lowest-index dirty stage is the one evaluated this cycle
    always_comb begin
        sel_idx = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (dirty_q[k]) begin
                sel_idx = IDXW'(k);
            end
        end
    end

    // Fetch the selected stage's source and apply its operator
    always_comb begin
        op_sel = OP[2*sel_idx +: 2];
        if (sel_idx == '0 || !SRC[sel_idx]) begin
            src_val = a_q;
        end else begin
            src_val = stage_q[sel_idx - 1'b1];
        end
        case (op_sel)
            2'b00:   res_val = src_val;
            2'b01:   res_val = (src_val == '0) ? WIDTH'(1) : '0;
            2'b10:   res_val = ~src_val;
            default: res_val = src_val + WIDTH'(1);
        endcase
    end

    // Retire the evaluated stage and wake its chained successor
    always_comb begin
`ifdef PROP_SCHED_CHANGE_DETECT_EN
        mark_next = (res_val != stage_q[sel_idx]);
`else
        mark_next = 1'b1;
`endif
        dirty_d          = dirty_q;
        dirty_d[sel_idx] = 1'b0;
        for (int k = 0; k < DEPTH - 1; k++) begin
            if (IDXW'(k) == sel_idx && SRC[k+1] && mark_next) begin
                dirty_d[k+1] = 1'b1;
            end
        end
    end

    // Read port: out-of-range index reads as zero
    always_comb begin
        rd_val = '0;
        if ({1'b0, rd_idx} < (IDXW+1)'(DEPTH)) begin
            rd_val = stage_q[rd_idx];
        end
    end

    // Control FSM and all state; reset forces a full sweep before IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= PROP;
            a_q        <= '0;
            dirty_q    <= '1;
            eval_cnt_q <= '0;
            done_q     <= 1'b0;
            in_ready_q <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= in_data;
                        dirty_q    <= accept_mark;
                        eval_cnt_q <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= PROP;
                    end
                end
                PROP: begin
                    if (|dirty_q) begin
                        stage_q[sel_idx] <= res_val;
                        dirty_q          <= dirty_d;
                        if (eval_cnt_q != 8'hFF) begin
                            eval_cnt_q <= eval_cnt_q + 8'd1;
                        end
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q     <= 1'b0;
                    in_ready_q <= 1'b1;
                    state_q    <= IDLE;
                end
                default: begin
                    done_q     <= 1'b0;
                    in_ready_q <= 1'b1;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign in_ready = in_ready_q;
    assign done     = done_q;
    assign rd_data  = rd_val;
    assign a_out    = a_q;
    assign eval_cnt = eval_cnt_q;

endmodule

// File: tb/tb_prop_sched.sv
// tb_prop_sched: scoreboard bench for prop_sched, default parameters.
// Expectations adapt to whether PROP_SCHED_CHANGE_DETECT_EN is defined.
`timescale 1ns/1ps
module tb_prop_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = '0;
    logic       in_ready;
    logic       done;
    logic [2:0] rd_idx = '0;
    logic [3:0] rd_data;
    logic [3:0] a_out;
    logic [7:0] eval_cnt;

    always #5 clk = ~clk;

    prop_sched dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .done     (done),
        .rd_idx   (rd_idx),
        .rd_data  (rd_data),
        .a_out    (a_out),
        .eval_cnt (eval_cnt)
    );

`ifdef PROP_SCHED_CHANGE_DETECT_EN
    localparam bit CD = 1'b1;
`else
    localparam bit CD = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]  a;
        logic [31:0] st;
        logic [7:0]  cnt;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // Settled chain for default OP/SRC: copy,copy,lnot,lnot,bnot,bnot,inc,inc
    function automatic logic [31:0] model(input logic [3:0] a);
        logic [3:0] s [8];
        s[0] = a;
        s[1] = s[0];
        s[2] = (a == 4'd0) ? 4'd1 : 4'd0;
        s[3] = (s[2] == 4'd0) ? 4'd1 : 4'd0;
        s[4] = ~a;
        s[5] = ~s[4];
        s[6] = a + 4'd1;
        s[7] = s[6] + 4'd1;
        return {s[7], s[6], s[5], s[4], s[3], s[2], s[1], s[0]};
    endfunction

    task automatic read_stages(output logic [31:0] s);
        for (int i = 0; i < 8; i++) begin
            rd_idx = 3'(i);
            #1;
            s[4*i +: 4] = rd_data;
        end
        rd_idx = '0;
    endtask

    task automatic wait_done(output int n, output bit rdy_seen);
        n = 0;
        rdy_seen = 1'b0;
        repeat (60) begin
            @(negedge clk);
            n++;
            if (in_ready) rdy_seen = 1'b1;
            if (done) return;
        end
        n = -1;
    endtask

    task automatic test_reset();
        exp_t e, g;
        int n;
        bit rdy_seen, d_after, r_after;
        logic [31:0] st;
        #1 rst_n = 1'b0;
        #2;
        tests++;
        if (in_ready !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctl: in_ready=%b done=%b want 0 0", in_ready, done);
        end
        tests++;
        if (a_out !== 4'd0 || eval_cnt !== 8'd0 || rd_data !== 4'd0) begin
            fails++;
            $display("FAIL reset_val: a=%h cnt=%0d rd=%h want 0 0 0", a_out, eval_cnt, rd_data);
        end
        e.a = 4'd0; e.st = model(4'd0); e.cnt = 8'd8;
        sb.push_back(e);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_done(n, rdy_seen);
        @(negedge clk);
        d_after = done; r_after = in_ready;
        read_stages(st);
        g = sb.pop_front();
        tests++;
        if (n !== int'(g.cnt) + 1) begin
            fails++;
            $display("FAIL reset_lat: got %0d want %0d", n, int'(g.cnt) + 1);
        end
        tests++;
        if (rdy_seen || d_after !== 1'b0 || r_after !== 1'b1) begin
            fails++;
            $display("FAIL reset_pulse: rdy_seen=%b done_after=%b rdy_after=%b", rdy_seen, d_after, r_after);
        end
        tests++;
        if (st !== g.st || eval_cnt !== g.cnt) begin
            fails++;
            $display("FAIL reset_sweep: st=%h cnt=%0d want %h %0d", st, eval_cnt, g.st, g.cnt);
        end
    endtask

    task automatic test_accept(input string name, input logic [3:0] a,
                               input logic [7:0] cnt, input bit hold);
        exp_t e, g;
        int n, guard;
        bit rdy_seen, d_after, r_after;
        logic [31:0] st;
        guard = 0;
        while (!in_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s ready: got %b want 1", name, in_ready);
        end
        e.a = a; e.st = model(a); e.cnt = cnt;
        sb.push_back(e);
        in_valid = 1'b1;
        in_data  = a;
        @(posedge clk);
        #1;
        if (hold) in_data = ~a;
        else in_valid = 1'b0;
        wait_done(n, rdy_seen);
        in_valid = 1'b0;
        @(negedge clk);
        d_after = done; r_after = in_ready;
        read_stages(st);
        g = sb.pop_front();
        tests++;
        if (n !== int'(g.cnt) + 2) begin
            fails++;
            $display("FAIL %s latency: got %0d want %0d", name, n, int'(g.cnt) + 2);
        end
        tests++;
        if (rdy_seen || d_after !== 1'b0 || r_after !== 1'b1) begin
            fails++;
            $display("FAIL %s pulse: rdy_seen=%b done_after=%b rdy_after=%b", name, rdy_seen, d_after, r_after);
        end
        tests++;
        if (st !== g.st) begin
            fails++;
            $display("FAIL %s stages: got %h want %h", name, st, g.st);
        end
        tests++;
        if (eval_cnt !== g.cnt || a_out !== g.a) begin
            fails++;
            $display("FAIL %s cnt_a: cnt=%0d a=%h want %0d %h", name, eval_cnt, a_out, g.cnt, g.a);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e, g;
        int n, guard;
        bit rdy_seen;
        logic [31:0] st;
        guard = 0;
        while (!in_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b1;
        in_data  = 4'd6;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (eval_cnt !== 8'd2) begin
            fails++;
            $display("FAIL mid_progress: cnt=%0d want 2", eval_cnt);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (a_out !== 4'd0 || eval_cnt !== 8'd0 || rd_data !== 4'd0 ||
            in_ready !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL mid_clear: a=%h cnt=%0d rd=%h rdy=%b done=%b want all 0",
                     a_out, eval_cnt, rd_data, in_ready, done);
        end
        e.a = 4'd0; e.st = model(4'd0); e.cnt = 8'd8;
        sb.push_back(e);
        @(negedge clk);
        rst_n = 1'b1;
        wait_done(n, rdy_seen);
        @(negedge clk);
        read_stages(st);
        g = sb.pop_front();
        tests++;
        if (n !== int'(g.cnt) + 1 || rdy_seen) begin
            fails++;
            $display("FAIL mid_lat: got %0d rdy_seen=%b want %0d 0", n, rdy_seen, int'(g.cnt) + 1);
        end
        tests++;
        if (st !== g.st || eval_cnt !== g.cnt || a_out !== g.a) begin
            fails++;
            $display("FAIL mid_sweep: st=%h cnt=%0d a=%h want %h %0d %h",
                     st, eval_cnt, a_out, g.st, g.cnt, g.a);
        end
    endtask

    initial begin
        test_reset();
        test_accept("accept_1", 4'h1, 8'd8, 1'b0);
        test_accept("repeat_1", 4'h1, CD ? 8'd0 : 8'd8, 1'b0);
        test_accept("wrap_F", 4'hF, CD ? 8'd7 : 8'd8, 1'b1);
        test_accept("back_to_0", 4'h0, 8'd8, 1'b0);
        test_reset_mid();
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_empty: %0d entries left want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/prop_sched.md
PROP_SCHED -- requirements
Module: prop_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning the stage and input value width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, meaning the number of assignment stages.
REQ-003 SHALL have parameter OP, default 16'hFA50, 2 bits per stage, OP[2k+1:2k]: 00 copy, 01 logical-not, 10 bitwise-not, 11 increment.
REQ-004 SHALL have parameter SRC, default 8'hAA, meaning for stage k: SRC[k]=0 sources a_q, SRC[k]=1 sources stage k-1; stage 0 always sources a_q.
REQ-005 SHALL have ports, clock and reset first:
- clk  in  1  sole clock; all state rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  new input value offered.
- in_data  in  WIDTH  value for a.
- in_ready  out  1  high only in IDLE.
- done  out  1  one-cycle pulse on settle.
- rd_idx  in  clog2(DEPTH)  stage select.
- rd_data  out  WIDTH  stage[rd_idx], combinational.
- a_out  out  WIDTH  current a_q.
- eval_cnt  out  8  evaluations since last accept.
REQ-006 SHALL use one clock domain; rst_n SHALL be asynchronous and active-low.

Function
REQ-007 SHALL implement an FSM with states IDLE, PROP and DONE.
REQ-008 IDLE: an accept (in_valid && in_ready) SHALL load a_q<=in_data, mark dirty every stage with SRC=a, clear eval_cnt, and go to PROP; any mark-suppression is governed by REQ-018.
REQ-009 PROP: each cycle SHALL evaluate exactly one stage, the lowest-index dirty one, write its result, and clear its dirty bit.
REQ-010 When a stage k result differs from its old value and stage k+1 has SRC=prev, stage k+1 SHALL be marked dirty; any mark-suppression is governed by REQ-018.
REQ-011 PROP with dirty==0 SHALL perform no evaluation and go to DONE.
REQ-012 DONE SHALL assert done for exactly one cycle, then go to IDLE; in_ready SHALL be low in PROP and DONE; in_valid there SHALL be ignored.
REQ-013 Operators SHALL follow these rules:
- logical-not yields 1 if the source is 0, else 0, zero-extended.
- bitwise-not inverts all WIDTH bits.
- increment yields +1 mod 2^WIDTH.
REQ-014 eval_cnt SHALL increment per evaluation and saturate at 255.
REQ-015 rd_idx>=DEPTH SHALL return rd_data=0.

Reset
REQ-016 rst_n low SHALL immediately set these values:
- a_q=0, all stages=0, eval_cnt=0, done=0, in_ready=0.
- all dirty bits=1.
- state=PROP.
REQ-017 Reset asserted mid-propagation SHALL discard pending work; after release, a full initial sweep SHALL run before IDLE.

Configuration
REQ-018 Macro PROP_SCHED_CHANGE_DETECT_EN SHALL control mark-suppression:
- defined: an accept whose in_data equals the old a_q marks nothing; downstream marks require a changed result.
- undefined: an accept marks all SRC=a stages unconditionally; each evaluation of stage k marks k+1 (if SRC=prev) regardless of change.

Verification
REQ-019 The bench SHALL cover, with default parameters and the macro defined:
- reset release -> 8 evaluations, done pulse; stages 0..7 = 0,0,1,0,F,0,1,2; eval_cnt=8.
- accept a=1 -> stages 1,1,0,1,E,1,2,3; eval_cnt=8; done exactly one cycle; in_ready low throughout.
- accept a=1 again -> eval_cnt=0, done in the 2nd cycle after accept, stages unchanged.
- accept a=F -> stage 6 wraps to 0, stage 7 = 1; logical-not stages = 0,1.
REQ-020 The bench SHALL cover, macro undefined: reset release, accept a=1, then accept a=1 again -> eval_cnt=8, stages unchanged.
REQ-021 The bench SHALL cover: rst_n pulsed low during PROP -> outputs clear asynchronously; reset sweep result matches the first REQ-019 scenario.
